// File: rtl/alsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_pkg
//  Description : Shared definitions for the ALSU result checker. Holds the
//                opcode map, checker FSM state encoding, bus widths and the
//                struct used to carry one cycle of tapped ALSU inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
package alsu_pkg;

    localparam int OPW  = 3;
    localparam int OUTW = 6;
    localparam int LEDW = 16;

    localparam logic [OPW-1:0] OP_AND   = 3'b000;
    localparam logic [OPW-1:0] OP_XOR   = 3'b001;
    localparam logic [OPW-1:0] OP_ADD   = 3'b010;
    localparam logic [OPW-1:0] OP_MULT  = 3'b011;
    localparam logic [OPW-1:0] OP_SHIFT = 3'b100;
    localparam logic [OPW-1:0] OP_ROT   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAIL  = 2'd3
    } chk_state_t;

    // One cycle worth of the pins the ALSU sees.
    typedef struct packed {
        logic           cin;
        logic           serial_in;
        logic           direction;
        logic           red_op_A;
        logic           red_op_B;
        logic           bypass_A;
        logic           bypass_B;
        logic [2:0]     A;
        logic [2:0]     B;
        logic [OPW-1:0] opcode;
    } alsu_in_t;

endpackage
`default_nettype wire

// File: rtl/alsu_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_checker_if
//  Description : Bundle between the harness (master) and the in-line ALSU
//                checker (slave). Carries the tapped ALSU inputs, the ALSU's
//                own out/leds, the enable, and all checker results.
//  Ports       : master drives taps/dut_*/check_en and reads results;
//                slave is the opposite direction.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alsu_checker_if #(
    parameter int CNT_W = 16
) ();
    import alsu_pkg::*;

    logic                 cin;
    logic                 serial_in;
    logic                 direction;
    logic                 red_op_A;
    logic                 red_op_B;
    logic                 bypass_A;
    logic                 bypass_B;
    logic [2:0]           A;
    logic [2:0]           B;
    logic [OPW-1:0]       opcode;
    logic [OUTW-1:0]      dut_out;
    logic [LEDW-1:0]      dut_leds;
    logic                 check_en;

    logic                 mismatch;
    logic                 error;
    logic [CNT_W-1:0]     chk_count;
    logic [CNT_W-1:0]     err_count;
    logic [OUTW+LEDW-1:0] first_exp;
    logic [OUTW+LEDW-1:0] first_act;
    logic [OPW-1:0]       first_op;

    modport master (
        output cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B,
        output A, B, opcode, dut_out, dut_leds, check_en,
        input  mismatch, error, chk_count, err_count, first_exp, first_act, first_op
    );

    modport slave (
        input  cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B,
        input  A, B, opcode, dut_out, dut_leds, check_en,
        output mismatch, error, chk_count, err_count, first_exp, first_act, first_op
    );

endinterface
`default_nettype wire

// File: rtl/alsu_ref_model.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_ref_model
//  Description : Cycle-accurate ALSU reference. Stage 1 registers the tapped
//                inputs, stage 2 computes the expected out/leds from them, so
//                the expected values appear 2 edges after the inputs, exactly
//                like the ALSU. Runs continuously so shift/rotate history and
//                the invalid-case LED toggle always track the real device.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_in           - tapped ALSU inputs
//                o_exp_out      - expected ALSU out
//                o_exp_leds     - expected ALSU leds
//                o_exp_op       - opcode that produced the current expectation
//  Revision    : 1.0 - initial release
// ============================================================================
module alsu_ref_model
    import alsu_pkg::*;
#(
    parameter INPUT_PRIORITY = "A",
    parameter FULL_ADDER     = "ON"
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  alsu_in_t             i_in,
    output logic [OUTW-1:0]      o_exp_out,
    output logic [LEDW-1:0]      o_exp_leds,
    output logic [OPW-1:0]       o_exp_op
);

    localparam bit c_PRIO_A = (INPUT_PRIORITY == "A");
    localparam bit c_FA     = (FULL_ADDER == "ON");

    alsu_in_t        r_s1;
    logic [OUTW-1:0] r_exp_out;
    logic [LEDW-1:0] r_exp_leds;
    logic [OPW-1:0]  r_exp_op;

    logic [OUTW-1:0] w_nxt_out;
    logic [LEDW-1:0] w_nxt_leds;
    logic            w_invalid;
    logic            w_red_a;
    logic            w_red_b;
    logic [OUTW-1:0] w_a_ext;
    logic [OUTW-1:0] w_b_ext;

    assign w_a_ext = {3'b000, r_s1.A};
    assign w_b_ext = {3'b000, r_s1.B};

    // Reduction flavour follows the opcode; only AND/XOR reach this path.
    assign w_red_a = (r_s1.opcode == OP_XOR) ? ^r_s1.A : &r_s1.A;
    assign w_red_b = (r_s1.opcode == OP_XOR) ? ^r_s1.B : &r_s1.B;

    assign w_invalid = (r_s1.opcode[2:1] == 2'b11) ||
                       ((r_s1.red_op_A || r_s1.red_op_B) &&
                        (r_s1.opcode != OP_AND) && (r_s1.opcode != OP_XOR));

    always_comb begin
        w_nxt_out  = '0;
        w_nxt_leds = '0;
        if (r_s1.bypass_A && r_s1.bypass_B) begin
            w_nxt_out = c_PRIO_A ? w_a_ext : w_b_ext;
        end else if (r_s1.bypass_A) begin
            w_nxt_out = w_a_ext;
        end else if (r_s1.bypass_B) begin
            w_nxt_out = w_b_ext;
        end else if (w_invalid) begin
            // LEDs blink while the invalid condition persists.
            w_nxt_leds = ~r_exp_leds;
        end else if (r_s1.red_op_A && (!r_s1.red_op_B || c_PRIO_A)) begin
            w_nxt_out = {5'b00000, w_red_a};
        end else if (r_s1.red_op_B) begin
            w_nxt_out = {5'b00000, w_red_b};
        end else begin
            case (r_s1.opcode)
                OP_AND:   w_nxt_out = w_a_ext & w_b_ext;
                OP_XOR:   w_nxt_out = w_a_ext ^ w_b_ext;
                OP_ADD:   w_nxt_out = w_a_ext + w_b_ext + {5'b00000, r_s1.cin & c_FA};
                OP_MULT:  w_nxt_out = w_a_ext * w_b_ext;
                OP_SHIFT: w_nxt_out = r_s1.direction ?
                                      {r_exp_out[OUTW-2:0], r_s1.serial_in} :
                                      {r_s1.serial_in, r_exp_out[OUTW-1:1]};
                OP_ROT:   w_nxt_out = r_s1.direction ?
                                      {r_exp_out[OUTW-2:0], r_exp_out[OUTW-1]} :
                                      {r_exp_out[0], r_exp_out[OUTW-1:1]};
                default:  w_nxt_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1       <= '0;
            r_exp_out  <= '0;
            r_exp_leds <= '0;
            r_exp_op   <= '0;
        end else begin
            r_s1       <= i_in;
            r_exp_out  <= w_nxt_out;
            r_exp_leds <= w_nxt_leds;
            r_exp_op   <= r_s1.opcode;
        end
    end

    assign o_exp_out  = r_exp_out;
    assign o_exp_leds = r_exp_leds;
    assign o_exp_op   = r_exp_op;

endmodule
`default_nettype wire

// File: rtl/alsu_checker.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_checker
//  Description : In-line ALSU result checker. Runs alsu_ref_model beside the
//                ALSU, compares expected against actual out/leds once per
//                cycle while in CHECK, counts compares and failures
//                (saturating) and latches the first failing pair.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                chk_bus   - alsu_checker_if.slave: taps, dut_out/dut_leds,
//                            check_en in; mismatch, error, counters and
//                            first-failure capture out
//  Revision    : 1.0 - initial release
// ============================================================================
module alsu_checker
    import alsu_pkg::*;
#(
    parameter INPUT_PRIORITY = "A",
    parameter FULL_ADDER     = "ON",
    parameter STOP_ON_ERR    = 0,
    parameter CNT_W          = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    alsu_checker_if.slave  chk_bus
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    alsu_in_t        w_in;
    logic [OUTW-1:0] w_exp_out;
    logic [LEDW-1:0] w_exp_leds;
    logic [OPW-1:0]  w_exp_op;
    logic            w_cmp;
    logic            w_diff;
    logic            w_fail;

    chk_state_t      r_state;
    chk_state_t      w_state_nxt;
    logic            r_prime_cnt;
    logic            w_prime_nxt;

    logic                 r_mismatch;
    logic                 r_error;
    logic [CNT_W-1:0]     r_chk_count;
    logic [CNT_W-1:0]     r_err_count;
    logic [OUTW+LEDW-1:0] r_first_exp;
    logic [OUTW+LEDW-1:0] r_first_act;
    logic [OPW-1:0]       r_first_op;

    assign w_in = {chk_bus.cin, chk_bus.serial_in, chk_bus.direction,
                   chk_bus.red_op_A, chk_bus.red_op_B,
                   chk_bus.bypass_A, chk_bus.bypass_B,
                   chk_bus.A, chk_bus.B, chk_bus.opcode};

    alsu_ref_model #(
        .INPUT_PRIORITY (INPUT_PRIORITY),
        .FULL_ADDER     (FULL_ADDER)
    ) u_ref (
        .clk        (clk),
        .rst        (rst),
        .i_in       (w_in),
        .o_exp_out  (w_exp_out),
        .o_exp_leds (w_exp_leds),
        .o_exp_op   (w_exp_op)
    );

    assign w_cmp  = (r_state == ST_CHECK) && chk_bus.check_en;
    assign w_diff = (chk_bus.dut_out != w_exp_out) || (chk_bus.dut_leds != w_exp_leds);
    assign w_fail = w_cmp && w_diff;

    // Next-state logic; PRIME waits two cycles for the pipeline to fill.
    always_comb begin
        w_state_nxt = r_state;
        w_prime_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (chk_bus.check_en) w_state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                if (!chk_bus.check_en)  w_state_nxt = ST_IDLE;
                else if (r_prime_cnt)   w_state_nxt = ST_CHECK;
                else                    w_prime_nxt = 1'b1;
            end
            ST_CHECK: begin
                if (!chk_bus.check_en)                  w_state_nxt = ST_IDLE;
                else if (w_diff && (STOP_ON_ERR != 0))  w_state_nxt = ST_FAIL;
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prime_cnt <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prime_cnt <= w_prime_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch  <= 1'b0;
            r_error     <= 1'b0;
            r_chk_count <= '0;
            r_err_count <= '0;
            r_first_exp <= '0;
            r_first_act <= '0;
            r_first_op  <= '0;
        end else begin
            r_mismatch <= w_fail;
            if (w_cmp && (r_chk_count != c_CNT_MAX)) begin
                r_chk_count <= r_chk_count + 1'b1;
            end
            if (w_fail) begin
                r_error <= 1'b1;
                if (r_err_count != c_CNT_MAX) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                // Only the very first failure is kept for debug.
                if (!r_error) begin
                    r_first_exp <= {w_exp_leds, w_exp_out};
                    r_first_act <= {chk_bus.dut_leds, chk_bus.dut_out};
                    r_first_op  <= w_exp_op;
                end
            end
        end
    end

    assign chk_bus.mismatch  = r_mismatch;
    assign chk_bus.error     = r_error;
    assign chk_bus.chk_count = r_chk_count;
    assign chk_bus.err_count = r_err_count;
    assign chk_bus.first_exp = r_first_exp;
    assign chk_bus.first_act = r_first_act;
    assign chk_bus.first_op  = r_first_op;

endmodule
`default_nettype wire

// File: doc/alsu_checker.md
Name: alsu_checker

Overview:
- Synthesizable in-line result checker for the ALSU. It taps the same input pins the ALSU sees, plus the ALSU's out and leds.
- Runs a cycle-accurate reference model with identical latency and compares the model against the DUT every cycle.
- Reports mismatches, counts checks and errors, and latches the first failure for debug.
- Sits beside the ALSU in the test harness and on FPGA, so random stimulus becomes self-checking.

Parameters:
- INPUT_PRIORITY, "A", operand chosen when both red_op_A/red_op_B or both bypass_A/bypass_B are set ("A" or "B").
- FULL_ADDER, "ON", "ON" makes add A+B+cin; "OFF" makes add A+B.
- STOP_ON_ERR, 0, 1 freezes checking in FAIL after the first mismatch.
- CNT_W, 16, width of the check and error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset; shared with the ALSU.
- cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B  in  1 each  ALSU input pins (tapped).
- A, B  in  3 each  ALSU operands (tapped).
- opcode  in  3  ALSU opcode (tapped).
- dut_out  in  6  ALSU out.
- dut_leds  in  16  ALSU leds.
- check_en  in  1  enables comparison.
- mismatch  out  1  one-cycle pulse on a compare failure.
- error  out  1  sticky failure flag.
- chk_count  out  CNT_W  number of compares performed (saturating).
- err_count  out  CNT_W  number of mismatches (saturating).
- first_exp  out  22  {exp_leds, exp_out} at the first failure.
- first_act  out  22  {dut_leds, dut_out} at the first failure.
- first_op  out  3  registered opcode at the first failure.

Behaviour:
- Model pipeline mirrors the ALSU:
  - Stage 1 registers all tapped inputs on every edge.
  - Stage 2 computes exp_out/exp_leds from the stage-1 values on the next edge.
  - Input-to-out latency is therefore 2 edges.
- Opcode map: 000 AND, 001 XOR, 010 ADD, 011 MULT, 100 SHIFT, 101 ROTATE, 110/111 invalid.
- Bypass has highest priority:
  - bypass_A alone gives exp_out = A; bypass_B alone gives exp_out = B.
  - Both set: INPUT_PRIORITY selects the operand.
  - Operands are zero-extended to 6 bits.
- Invalid condition (checked after bypass): opcode 110/111, or any red_op set with an opcode other than AND/XOR.
  - exp_out = 0.
  - exp_leds = ~exp_leds, i.e. toggles every cycle.
- All non-invalid cases: exp_leds = 0.
- AND/XOR with reduction: red_op_A gives &A or ^A; red_op_B gives &B or ^B; both set resolved by INPUT_PRIORITY. Result is zero-extended.
- AND/XOR without reduction: bitwise A op B, zero-extended.
- ADD: A+B+cin (or A+B when FULL_ADDER="OFF"), 6 bits, no overflow possible (max 15).
- MULT: A*B, 6 bits (max 49).
- SHIFT (uses the model's own previous exp_out):
  - direction=1: {exp_out[4:0], serial_in}.
  - direction=0: {serial_in, exp_out[5:1]}.
- ROTATE:
  - direction=1: {exp_out[4:0], exp_out[5]}.
  - direction=0: {exp_out[0], exp_out[5:1]}.
- FSM states: IDLE, PRIME, CHECK, FAIL.
  - IDLE -> PRIME when check_en=1.
  - PRIME lasts 2 cycles (pipeline fill, no compares) -> CHECK.
  - CHECK -> IDLE when check_en=0.
  - CHECK -> FAIL on mismatch when STOP_ON_ERR=1.
  - FAIL exits only via rst.
- Compare in CHECK only, once per cycle:
  - chk_count increments.
  - A difference in out or leds pulses mismatch, sets error, and increments err_count.
  - The first_* registers capture only while error=0.
- Counters saturate at all-ones and do not wrap.
- Reset (rst=1 at an edge):
  - All pipeline registers, exp_out and exp_leds cleared to 0.
  - All outputs cleared to 0; state = IDLE.
  - Reset asserted mid-CHECK or in FAIL aborts immediately; no compare happens that cycle.
- check_en dropping mid-PRIME returns to IDLE. The model keeps tracking regardless of state, so shift/rotate history stays valid.

Decomposition:
- alsu_pkg holds:
  - Opcode localparams (OP_AND..OP_ROT).
  - Checker state encodings.
  - Widths: OPW=3, OUTW=6, LEDW=16.
- Sub-module alsu_ref_model:
  - Contains both pipeline stages and the exp_out/exp_leds registers.
  - Has its own clk and rst ports.
- alsu_checker keeps the FSM, the comparator, the counters and the first-failure capture.

Test Plan:
- Reset, then check_en=1, A=3, B=5, opcode=010, cin=1 held -> after PRIME, exp_out=9 matching DUT; error=0 and chk_count counts up.
- opcode=011, A=7, B=7 -> exp_out=49 (6'b110001); opcode=001 with red_op_A=1, A=3'b110 -> exp_out=0.
- From out=6'b000001: opcode=100, direction=1, serial_in=1 over 3 cycles -> 000011, 000111, 001111; then opcode=101, direction=0 -> 100111.
- opcode=110 for 4 cycles -> out=0, leds FFFF, 0000, FFFF, 0000; opcode=000 with red_op_B=1 -> valid, leds=0.
- Force dut_out=6'h3F for one CHECK cycle while exp_out=9 -> mismatch pulse, error=1, err_count=1, first_exp[5:0]=9, first_act[5:0]=3F; with STOP_ON_ERR=1 state=FAIL and chk_count freezes.
- rst pulsed in FAIL -> all outputs 0, state IDLE; check_en held 1 -> re-primes and resumes compares 2 cycles later.
